switch_debouncer: RTL and testbench

Multi-channel switch/push-button conditioner that sits directly upstream of the board-level flip-flop and counter demos, turning raw slide-switch and button pins into clean, synchronized levels plus single-cycle edge pulses. Each channel has a two-flop synchronizer, a per-channel stability counter and a small state machine. Outputs drive the J/K/preset/reset style control inputs of downstream sequential blocks directly, so no metastable or bouncing level reaches them.

---
 rtl/switch_debouncer.sv | 151 +++++++++++++++
 tb/tb_switch_debouncer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Multi-channel switch / push-button conditioner. Each channel passes its raw
// pin through a two-flop synchronizer, then a small per-channel state machine
// with its own stability counter decides when the synchronized level has been
// steady long enough to be accepted as the new debounced level. Every accepted
// change produces a single-cycle rise or fall pulse. any_change flags that at
// least one channel pulsed in this cycle.
//
// Parameters:
//   WIDTH          number of independent channels (1..16)
//   STABLE_CYCLES  consecutive cycles the synchronized input must differ from
//                  the debounced level before the level follows (2..2^24)
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-low reset
//   sw_in       raw asynchronous switch pins
//   sw_out      debounced, registered level per channel
//   rise        one-cycle pulse when sw_out goes 0->1
//   fall        one-cycle pulse when sw_out goes 1->0
//   any_change  OR of all rise/fall bits, coincident with them
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // The counter holds 1 on the first cycle of a difference, so reaching
    // STABLE_CYCLES-1 while still different means the STABLE_CYCLES-th
    // consecutive differing sample is being seen now.
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } chan_state_t;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    chan_state_t      state_q [WIDTH];
    chan_state_t      state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. Only s2 is allowed to reach the state machines.
    // -------------------------------------------------------------------------
    // NOTE: sequential state always uses non-blocking assignments so that s2
    // picks up the old s1 on the same edge, giving a true two-stage pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // -------------------------------------------------------------------------
    // State, counter and output registers.
    // -------------------------------------------------------------------------
    // NOTE: the per-channel counter arrays are ordinary flops, not a RAM, so
    // they are cleared on reset along with the rest; a reset mid-qualification
    // must discard any partial count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            sw_out     <= '0;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sw_out     <= out_d;
            rise       <= rise_d;
            fall       <= fall_d;
            any_change <= |(rise_d | fall_d);
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel next-state logic.
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = sw_out;
        rise_d  = '0;
        fall_d  = '0;

        for (int i = 0; i < WIDTH; i++) begin
            unique case (state_q[i])
                ST_STABLE: begin
                    if (s2[i] != sw_out[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end

                ST_PENDING: begin
                    if (s2[i] == sw_out[i]) begin
                        // Bounced back: throw the count away, no partial credit.
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                        out_d[i]   = s2[i];
                        rise_d[i]  = s2[i];
                        fall_d[i]  = ~s2[i];
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end

                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed scenarios with expectations written as explicit edge numbers, plus a
// randomized run checked against a behavioural model. The model tracks, per
// channel, how many consecutive cycles the twice-delayed input has disagreed
// with the debounced level; when that run reaches STABLE the level flips.
// Inputs are driven after the falling edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int WIDTH  = 4;
    localparam int STABLE = 8;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic [WIDTH-1:0] sw_in = '0;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_change;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    logic [WIDTH-1:0] m_s1   = '0;
    logic [WIDTH-1:0] m_s2   = '0;
    logic [WIDTH-1:0] m_out  = '0;
    logic [WIDTH-1:0] m_rise = '0;
    logic [WIDTH-1:0] m_fall = '0;
    logic             m_any  = 1'b0;
    int               run [WIDTH];

    switch_debouncer #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .sw_out     (sw_out),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    // Advance the model by one rising edge using the inputs present now.
    task automatic model_step();
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] f;
        r = '0;
        f = '0;
        if (!rst) begin
            m_s1  = '0;
            m_s2  = '0;
            m_out = '0;
            for (int ch = 0; ch < WIDTH; ch++) run[ch] = 0;
        end else begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                if (m_s2[ch] != m_out[ch]) begin
                    run[ch] = run[ch] + 1;
                    if (run[ch] == STABLE) begin
                        m_out[ch] = m_s2[ch];
                        if (m_s2[ch]) r[ch] = 1'b1;
                        else          f[ch] = 1'b1;
                        run[ch] = 0;
                    end
                end else begin
                    run[ch] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = sw_in;
        end
        m_rise = r;
        m_fall = f;
        m_any  = |(r | f);
    endtask

    // One clock: rising edge (DUT and model update), then park on the falling
    // edge where outputs are sampled and new inputs are driven.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        sw_in = '0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [3*WIDTH:0] got;
        sw_in = 4'($urandom);
        rst   = 1'b0;
        tick();
        tick();
        got = {sw_out, rise, fall, any_change};
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, want all zero", got);
        end
        do_reset();
        got = {sw_out, rise, fall, any_change};
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_release_idle: got %b, want all zero", got);
        end
    endtask

    // Clean 0->1 on channel 0: level and rise at E10, pulse gone at E11.
    task automatic test_clean_step();
        logic [3*WIDTH:0] got, exp;
        do_reset();
        sw_in = 4'b0001;
        for (int e = 1; e <= 12; e++) begin
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {(e >= 10) ? 4'b0001 : 4'b0000,
                   (e == 10) ? 4'b0001 : 4'b0000,
                   4'b0000,
                   (e == 10)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL clean_step E%0d: got %b, want %b", e, got, exp);
            end
        end
    endtask

    // Channel 1 toggles 1,0,1,0 for 3 cycles each, then holds 1.
    // The final hold starts at cycle 13, so its E10 is cycle 22.
    task automatic test_bounce();
        logic [3*WIDTH:0] got, exp;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            sw_in[1] = (k > 12) ? 1'b1 : (((k - 1) / 3) % 2 == 0);
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {(k >= 22) ? 4'b0010 : 4'b0000,
                   (k == 22) ? 4'b0010 : 4'b0000,
                   4'b0000,
                   (k == 22)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL bounce cycle %0d: got %b, want %b", k, got, exp);
            end
        end
    endtask

    // Continues from test_bounce (sw_out = 0010): raise ch2, then release it.
    task automatic test_release();
        logic [3*WIDTH:0] got, exp;
        sw_in[2] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {(e >= 10) ? 4'b0110 : 4'b0010,
                   (e == 10) ? 4'b0100 : 4'b0000,
                   4'b0000,
                   (e == 10)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL release_rise E%0d: got %b, want %b", e, got, exp);
            end
        end
        sw_in[2] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {(e >= 10) ? 4'b0010 : 4'b0110,
                   4'b0000,
                   (e == 10) ? 4'b0100 : 4'b0000,
                   (e == 10)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL release_fall E%0d: got %b, want %b", e, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3*WIDTH:0] got, exp;
        do_reset();
        sw_in = 4'b1010;
        for (int e = 1; e <= 12; e++) begin
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {(e >= 10) ? 4'b1010 : 4'b0000,
                   (e == 10) ? 4'b1010 : 4'b0000,
                   4'b0000,
                   (e == 10)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL simultaneous E%0d: got %b, want %b", e, got, exp);
            end
        end
    endtask

    // rst low at E6 of a qualification; counting restarts at the next edge.
    task automatic test_reset_mid_count();
        logic [3*WIDTH:0] got, exp;
        do_reset();
        sw_in = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            if (e == 6) rst = 1'b0;
            tick();
            got = {sw_out, rise, fall, any_change};
            tests++;
            if (got !== '0) begin
                fails++;
                $display("FAIL reset_mid E%0d: got %b, want all zero", e, got);
            end
        end
        rst = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {(e >= 10) ? 4'b0001 : 4'b0000,
                   (e == 10) ? 4'b0001 : 4'b0000,
                   4'b0000,
                   (e == 10)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL reset_mid_restart E%0d: got %b, want %b", e, got, exp);
            end
        end
    endtask

    // Input high for STABLE-1 sampled cycles: never qualifies.
    task automatic test_near_miss();
        logic [3*WIDTH:0] got;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            sw_in = (k <= STABLE - 1) ? 4'b0001 : 4'b0000;
            tick();
            got = {sw_out, rise, fall, any_change};
            tests++;
            if (got !== '0) begin
                fails++;
                $display("FAIL near_miss cycle %0d: got %b, want all zero", k, got);
            end
        end
    endtask

    // Input high for exactly STABLE sampled cycles: qualifies at E10, and the
    // return to 0 then qualifies 8 samples later at E18.
    task automatic test_exact_boundary();
        logic [3*WIDTH:0] got, exp;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            sw_in = (e <= STABLE) ? 4'b0001 : 4'b0000;
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {(e >= 10 && e < 18) ? 4'b0001 : 4'b0000,
                   (e == 10) ? 4'b0001 : 4'b0000,
                   (e == 18) ? 4'b0001 : 4'b0000,
                   (e == 10 || e == 18)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL exact_boundary E%0d: got %b, want %b", e, got, exp);
            end
        end
    endtask

    // Random per-channel hold lengths with occasional resets, against the model.
    task automatic test_random();
        logic [3*WIDTH:0] got, exp;
        int hold [WIDTH];
        int pulses;
        int shown;
        pulses = 0;
        shown  = 0;
        for (int ch = 0; ch < WIDTH; ch++) hold[ch] = 0;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                if (hold[ch] == 0) begin
                    sw_in[ch] = 1'($urandom);
                    hold[ch]  = $urandom_range(1, 12);
                end
                hold[ch]--;
            end
            rst = ($urandom_range(0, 199) != 0);
            tick();
            got = {sw_out, rise, fall, any_change};
            exp = {m_out, m_rise, m_fall, m_any};
            if (m_any) pulses++;
            tests++;
            if (got !== exp || (rise & fall) !== '0) begin
                fails++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle %0d: got %b, want %b", k, got, exp);
                end
            end
        end
        rst = 1'b1;
        tests++;
        if (pulses == 0) begin
            fails++;
            $display("FAIL random_activity: got %0d model pulses, want > 0", pulses);
        end
    endtask

    initial begin
        for (int ch = 0; ch < WIDTH; ch++) run[ch] = 0;
        @(negedge clk);
        test_reset();
        test_clean_step();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid_count();
        test_near_miss();
        test_exact_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
